uart_tx_serializer: RTL and testbench

//   8-bit UART transmit serializer. Sits directly downstream of uartTxBuf.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx_serializer.sv | 136 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, data width and baud divisor helper.
// Used by the transmit serializer and intended for the receiver as well.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int UART_DATA_BITS = 8;

   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: down-counter reloaded with DIV-1, bit_end high while the count is 0.
// restart aligns a fresh bit period to the cycle after it is asserted.
module uart_baud_gen #(
   parameter int DIV = 104
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic bit_end
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (restart || (cnt == '0)) begin
         cnt <= LOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLK_HZ    = 12_000_000,
   parameter int BAUD      = 115_200,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] utb_txdata,
   input  logic       utb_txdata_rdy,
   output logic       txBusy,
   output logic       tx
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);
   localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   uart_state_e               state, state_d;
   logic [UART_DATA_BITS-1:0] shreg, shreg_d;
   logic [2:0]                bit_cnt, bit_cnt_d;
   logic                      tx_d, busy_d;
   logic                      restart, bit_end;
`ifdef UART_TX_PARITY_EN
   logic                      parity, parity_d;
`endif

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (restart),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d   = state;
      shreg_d   = shreg;
      bit_cnt_d = bit_cnt;
      tx_d      = tx;
      busy_d    = txBusy;
      restart   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity;
`endif
      case (state)
         IDLE: begin
            if (utb_txdata_rdy) begin
               shreg_d   = utb_txdata;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^utb_txdata;
`endif
               restart   = 1'b1;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d    = shreg[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  tx_d      = parity;
                  state_d   = PARITY;
`else
                  tx_d      = 1'b1;
                  state_d   = STOP;
`endif
               end else begin
                  // shreg[0] is the bit currently on the line, so the next one is shreg[1]
                  bit_cnt_d = bit_cnt + 3'd1;
                  shreg_d   = shreg >> 1;
                  tx_d      = shreg[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (bit_cnt == LAST_STOP) begin
                  bit_cnt_d = '0;
                  busy_d    = 1'b0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt + 3'd1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         tx      <= 1'b1;
         txBusy  <= 1'b0;
         bit_cnt <= '0;
      end else begin
         state   <= state_d;
         tx      <= tx_d;
         txBusy  <= busy_d;
         bit_cnt <= bit_cnt_d;
      end
   end

   // Payload registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      shreg  <= shreg_d;
`ifdef UART_TX_PARITY_EN
      parity <= parity_d;
`endif
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-level line model checked every cycle plus literal frame checks.
module tb_uart_tx_serializer;

   localparam int DIV = 104;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       rdy0 = 1'b0, rdy1 = 1'b0;
   logic       tx0, tx1, busy0, busy1;
   int         errors = 0, checks = 0;
   bit         chk_en = 1'b0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLK_HZ(12_000_000), .BAUD(115_200), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .utb_txdata(data0), .utb_txdata_rdy(rdy0),
      .txBusy(busy0), .tx(tx0));

   uart_tx_serializer #(.CLK_HZ(12_000_000), .BAUD(115_200), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .utb_txdata(data1), .utb_txdata_rdy(rdy1),
      .txBusy(busy1), .tx(tx1));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic get_tx(input int k);
      return (k == 0) ? tx0 : tx1;
   endfunction

   function automatic logic get_busy(input int k);
      return (k == 0) ? busy0 : busy1;
   endfunction

   // Frame model: a frame is a list of line bits, each held DIV cycles.
   function automatic int frame_len(input int stop);
      return (1 + 8 + P + stop) * DIV;
   endfunction

   function automatic logic line_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (P == 1 && idx == 9) return ^d;
      return 1'b1;
   endfunction

   bit         m_act[2];
   int         m_pos[2];
   logic [7:0] m_byte[2];
   logic [7:0] accq[$];
   logic       m_r;
   logic [7:0] m_d;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0;
            m_pos[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_r = (k == 0) ? rdy0 : rdy1;
            m_d = (k == 0) ? data0 : data1;
            if (m_act[k]) begin
               m_pos[k]++;
               if (m_pos[k] == frame_len(k + 1)) begin
                  m_act[k] = 1'b0;
                  m_pos[k] = 0;
               end
            end else if (m_r) begin
               m_act[k]  = 1'b1;
               m_pos[k]  = 0;
               m_byte[k] = m_d;
               if (k == 0) accq.push_back(m_d);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int c = 0; c < 2; c++) begin
            check($sformatf("tx%0d_cycle", c), get_tx(c),
                  m_act[c] ? line_bit(m_byte[c], m_pos[c] / DIV) : 1'b1);
            check($sformatf("busy%0d_cycle", c), get_busy(c), m_act[c]);
         end
      end
   end

   task automatic strobe(input int k, input logic [7:0] d);
      @(negedge clk);
      if (k == 0) begin data0 = d; rdy0 = 1'b1; end
      else        begin data1 = d; rdy1 = 1'b1; end
      @(negedge clk);
      if (k == 0) begin data0 = 8'h00; rdy0 = 1'b0; end
      else        begin data1 = 8'h00; rdy1 = 1'b0; end
   endtask

   task automatic wait_idle(input int k, input string nm);
      int n;
      n = 0;
      while (get_busy(k) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_idle"}, get_busy(k), 1'b0);
   endtask

   // e holds the expected line bits in transmission order, e[0] = start bit.
   task automatic literal_frame(input int k, input logic [7:0] d, input logic [0:11] e,
                                input int nb, input int exp_len, input string nm);
      int i;
      strobe(k, d);
      check({nm, "_busy_next"}, get_busy(k), 1'b1);
      i = 0;
      while (get_busy(k) && i < 3000) begin
         if ((i % DIV) == DIV / 2 && (i / DIV) < nb)
            check($sformatf("%s_bit%0d", nm, i / DIV), get_tx(k), e[i / DIV]);
         @(negedge clk);
         i++;
      end
      check({nm, "_len"}, i, exp_len);
      check({nm, "_tx_idle"}, get_tx(k), 1'b1);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:11] e;
      int gap;

      repeat (3) @(negedge clk);
      check("rst_tx0", tx0, 1'b1);
      check("rst_busy0", busy0, 1'b0);
      check("rst_tx1", tx1, 1'b1);
      check("rst_busy1", busy1, 1'b0);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Asynchronous reset in the middle of a frame
      strobe(0, 8'h3C);
      repeat (300) @(negedge clk);
      check("mid_busy", busy0, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("async_tx", tx0, 1'b1);
      check("async_busy", busy0, 1'b0);
      repeat (6) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // 0x55 at defaults
`ifdef UART_TX_PARITY_EN
      e = 12'b0_10101010_0_11;
`else
      e = 12'b0_10101010_1_11;
`endif
      literal_frame(0, 8'h55, e, 10 + P, 1040 + 104 * P, "f55");

      // 0xA3: data 1,1,0,0,0,1,0,1, parity 0
`ifdef UART_TX_PARITY_EN
      e = 12'b0_11000101_0_11;
`else
      e = 12'b0_11000101_1_11;
`endif
      literal_frame(0, 8'hA3, e, 10 + P, 1040 + 104 * P, "fA3");

      // Strobe while busy is dropped
      accq.delete();
      strobe(0, 8'h12);
      repeat (8) @(negedge clk);
      strobe(0, 8'h34);
      wait_idle(0, "drop");
      repeat (20) @(negedge clk);
      check("drop_no_second", busy0, 1'b0);
      check("drop_count", accq.size(), 1);
      if (accq.size() > 0) check("drop_byte", accq[0], 8'h12);

      // Back-to-back frames
      accq.delete();
      strobe(0, 8'h41);
      wait_idle(0, "ab_first");
      gap = 0;
      while (!busy0 && gap < 10) begin
         if (gap == 0) begin data0 = 8'h42; rdy0 = 1'b1; end
         @(negedge clk);
         rdy0 = 1'b0;
         data0 = 8'h00;
         gap++;
      end
      check("ab_gap", gap, 1);
      wait_idle(0, "ab_second");
      check("ab_count", accq.size(), 2);
      if (accq.size() == 2) begin
         check("ab_byte0", accq[0], 8'h41);
         check("ab_byte1", accq[1], 8'h42);
      end

      // Two stop bits with 0xFF
      e = 12'b0_11111111_0_11;
      if (P == 0) e = 12'b0_11111111_1_11;
      literal_frame(1, 8'hFF, e, 11 + P, 1144 + 104 * P, "fFF2");

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
